// File: rtl/hdb3_pkg.sv
// hdb3_pkg: shared constants and state encoding for the HDB3 transmit controller.
package hdb3_pkg;
    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 8'h1B;
    typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_SYNC, ST_DATA, ST_GAP} state_t;
endpackage

// File: rtl/hdb3_word_buf.sv
// hdb3_word_buf: one-entry payload holding register with ready/full handshake.
module hdb3_word_buf
    import hdb3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    input  logic              unload,
    output logic              word_ready,
    output logic              buf_full,
    output logic [WORD_W-1:0] buf_data
);
    logic load;

    assign word_ready = !buf_full;
    assign load = word_valid && word_ready;

    // A load into an empty register wins over an unload that found it empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            buf_full <= load || (buf_full && !unload);
            buf_data <= load ? word_data : buf_data;
        end
    end
endmodule

// File: rtl/hdb3_tx_ctrl.sv
// hdb3_tx_ctrl: frames payload words behind a sync header and serialises them
// MSB-first towards the HDB3 encoder, with an inter-frame zero gap.
module hdb3_tx_ctrl
    import hdb3_pkg::*;
#(
    parameter int                FRAME_LEN = 4,
    parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int                GAP_LEN   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              frame_sync,
    output logic              enc_rst_n,
    output logic              underrun,
    output logic              busy
);
    state_t            state;
    logic              buf_full;
    logic              unload;
    logic [WORD_W-1:0] buf_data;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] sr;
    logic [2:0]        bit_cnt;
    logic [7:0]        word_cnt;
    logic [3:0]        gap_cnt;

    hdb3_word_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .word_valid (word_valid),
        .word_data  (word_data),
        .unload     (unload),
        .word_ready (word_ready),
        .buf_full   (buf_full),
        .buf_data   (buf_data)
    );

    // Unload while the last bit of the header or a non-final word is on the line.
    assign unload = bit_cnt == 3'd7 &&
                    (state == ST_SYNC || (state == ST_DATA && word_cnt != 8'(FRAME_LEN - 1)));
    assign word = buf_full ? buf_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            gap_cnt    <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            frame_sync <= 1'b0;
            enc_rst_n  <= 1'b0;
            underrun   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_sync <= 1'b0;
            underrun   <= 1'b0;
            enc_rst_n  <= 1'b1;
            case (state)
                ST_IDLE: if (en && buf_full) begin
                    state     <= ST_CLEAR;
                    enc_rst_n <= 1'b0;
                    busy      <= 1'b1;
                end
                ST_CLEAR: begin
                    state      <= ST_SYNC;
                    bit_out    <= SYNC_WORD[WORD_W-1];
                    sr         <= {SYNC_WORD[WORD_W-2:0], 1'b0};
                    bit_cnt    <= '0;
                    bit_valid  <= 1'b1;
                    frame_sync <= 1'b1;
                end
                ST_SYNC, ST_DATA: if (unload) begin
                    state    <= ST_DATA;
                    bit_out  <= word[WORD_W-1];
                    sr       <= {word[WORD_W-2:0], 1'b0};
                    underrun <= !buf_full;
                    word_cnt <= (state == ST_SYNC) ? 8'd0 : word_cnt + 8'd1;
                    bit_cnt  <= bit_cnt + 3'd1;
                end else if (bit_cnt == 3'd7) begin
                    state     <= ST_GAP;
                    bit_out   <= 1'b0;
                    bit_valid <= 1'b0;
                    bit_cnt   <= '0;
                    word_cnt  <= '0;
                    gap_cnt   <= '0;
                end else begin
                    bit_out <= sr[WORD_W-1];
                    sr      <= {sr[WORD_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ST_GAP: if (gap_cnt == 4'(GAP_LEN - 1)) begin
                    state     <= (en && buf_full) ? ST_CLEAR : ST_IDLE;
                    enc_rst_n <= !(en && buf_full);
                    busy      <= en && buf_full;
                end else begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hdb3_tx_ctrl.sv
// tb_hdb3_tx_ctrl: directed checks of framing, latency, underrun, back-to-back,
// enable drop, mid-frame reset and backpressure.
module tb_hdb3_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst, en, word_valid, feed;
    logic [7:0] word_data;
    logic       word_ready, bit_out, bit_valid, frame_sync, enc_rst_n, underrun, busy;

    int         n_chk = 0, n_err = 0;
    int         cyc = 0, acc_n, viol, first_acc, pay_cyc, clr_cyc, clr_n, last_bit, idle_cyc, gap_one;
    logic       acc, prev_acc, went_busy;
    logic [7:0] src[$];
    logic [7:0] junk;
    logic       rx[$];
    int         fs_cyc[$];
    int         ur_pos[$];

    hdb3_tx_ctrl #(.FRAME_LEN(4), .SYNC_WORD(8'h1B), .GAP_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .frame_sync (frame_sync),
        .enc_rst_n  (enc_rst_n),
        .underrun   (underrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] frame_bits(input int off);
        logic [39:0] r;
        for (int i = 0; i < 40; i++) r[39-i] = (off + i < rx.size()) ? rx[off+i] : 1'bx;
        return r;
    endfunction

    // Word source, acceptance tracking and output monitor in one process.
    initial begin
        word_valid = 1'b0;
        word_data  = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            acc = word_valid && word_ready && !rst;
            if (acc) begin
                junk = src.pop_front();
                acc_n++;
                if (first_acc < 0) first_acc = cyc;
                if (prev_acc) viol++;
            end
            prev_acc = acc;
            #1;
            if (bit_valid) begin
                rx.push_back(bit_out);
                last_bit = cyc;
                if (rx.size() == 9) pay_cyc = cyc;
            end
            if (frame_sync) fs_cyc.push_back(cyc);
            if (underrun) ur_pos.push_back(rx.size() - 1);
            if (!enc_rst_n && !rst) begin
                clr_n++;
                if (clr_cyc < 0) clr_cyc = cyc;
            end
            if (busy && !bit_valid && bit_out) gap_one++;
            if (busy) went_busy = 1'b1;
            else if (went_busy && idle_cyc < 0) idle_cyc = cyc;
            word_valid = feed && src.size() > 0;
            word_data  = (src.size() > 0) ? src[0] : 8'h00;
        end
    end

    task automatic start_test();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; feed = 1'b0;
        repeat (2) @(negedge clk);
        src.delete(); rx.delete(); fs_cyc.delete(); ur_pos.delete();
        acc_n = 0; viol = 0; first_acc = -1; pay_cyc = -1; clr_cyc = -1; clr_n = 0;
        last_bit = -1; idle_cyc = -1; gap_one = 0; prev_acc = 1'b0; went_busy = 1'b0;
    endtask

    task automatic go(input logic [7:0] w[$]);
        src = w;
        rst = 1'b0; en = 1'b1; feed = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen = 1'b0, done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_bits(input string tag, input int n);
        int k = 0;
        while (rx.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, rx.size(), n);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; feed = 1'b0;

        // Single frame, reset values, latency, gap
        start_test();
        check("rst_outputs", {word_ready, bit_out, bit_valid, frame_sync, enc_rst_n, underrun, busy}, 7'b1000000);
        go('{8'hFF, 8'h00, 8'h81, 8'h0F});
        @(negedge clk);
        check("enc_release", enc_rst_n, 1'b1);
        wait_done("t1_done", 200);
        check("t1_bits", frame_bits(0), 40'h1B_FF00810F);
        check("t1_nbits", rx.size(), 40);
        check("t1_clear_lat", clr_cyc - first_acc, 1);
        check("t1_sync_lat", fs_cyc[0] - first_acc, 2);
        check("t1_data_lat", pay_cyc - first_acc, 10);
        check("t1_clear_len", clr_n, 1);
        check("t1_nsync", fs_cyc.size(), 1);
        check("t1_gap_len", idle_cyc - last_bit, 5);
        check("t1_gap_zero", gap_one, 0);
        check("t1_no_underrun", ur_pos.size(), 0);

        // Underrun: two words for a four-word frame
        start_test();
        go('{8'hA5, 8'h3C});
        wait_done("t2_done", 200);
        check("t2_bits", frame_bits(0), 40'h1B_A53C0000);
        check("t2_nunder", ur_pos.size(), 2);
        check("t2_under3", (ur_pos.size() > 0) ? ur_pos[0] : -1, 24);
        check("t2_under4", (ur_pos.size() > 1) ? ur_pos[1] : -1, 32);

        // Back-to-back frames
        start_test();
        go('{8'hC3, 8'hA5, 8'h5A, 8'h3C, 8'h01, 8'h02, 8'h80, 8'h40});
        wait_done("t3_done", 300);
        check("t3_nsync", fs_cyc.size(), 2);
        check("t3_spacing", (fs_cyc.size() > 1) ? fs_cyc[1] - fs_cyc[0] : -1, 45);
        check("t3_frame1", frame_bits(0), 40'h1B_C3A55A3C);
        check("t3_frame2", frame_bits(40), 40'h1B_01028040);
        check("t3_clears", clr_n, 2);

        // en dropped in the second payload word; fifth word stays held
        start_test();
        go('{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A});
        wait_bits("t4_reach_w2", 19);
        en = 1'b0;
        wait_done("t4_done", 200);
        check("t4_bits", frame_bits(0), 40'h1B_12345678);
        check("t4_nbits", rx.size(), 40);
        repeat (5) @(negedge clk);
        check("t4_idle", busy, 1'b0);
        check("t4_held", word_ready, 1'b0);

        // Reset in DATA with a word held
        start_test();
        go('{8'hE7, 8'h66, 8'h99, 8'h18});
        wait_bits("t5_reach_data", 12);
        feed = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_outputs", {word_ready, bit_out, bit_valid, frame_sync, enc_rst_n, underrun, busy}, 7'b1000000);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_stays_idle", busy, 1'b0);
        check("t5_discarded", word_ready, 1'b1);
        check("t5_aborted", rx.size(), 12);

        // Backpressure: words always offered across three frames
        start_test();
        go('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC});
        wait_done("t6_done", 400);
        check("t6_accepted", acc_n, 12);
        check("t6_ready_runs", viol, 0);
        check("t6_frame1", frame_bits(0), 40'h1B_11223344);
        check("t6_frame2", frame_bits(40), 40'h1B_55667788);
        check("t6_frame3", frame_bits(80), 40'h1B_99AABBCC);
        check("t6_nbits", rx.size(), 120);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
